// File: rtl/db_req_arb.sv
// Round-robin SRIO doorbell request generator driving the ireq AXI-Stream port.
// Optional DB_STATS_EN adds sent/drop statistics counters.
module db_req_arb #(
    parameter int         NUM_CH   = 4,
    parameter logic [1:0] PRIO     = 2'h1,
    parameter logic [7:0] TID_INIT = 8'h00
) (
    input  logic                 log_clk,
    input  logic                 rst,
    input  logic [15:0]          src_id,
    input  logic [15:0]          des_id,
    input  logic [NUM_CH-1:0]    db_req_in,
    input  logic [NUM_CH*16-1:0] db_info_in,
    output logic [NUM_CH-1:0]    db_pending_o,
    output logic [NUM_CH-1:0]    db_drop_o,
    output logic                 busy_o,
    output logic                 ireq_tvalid_o,
    input  logic                 ireq_tready_in,
    output logic                 ireq_tlast_o,
    output logic [63:0]          ireq_tdata_o,
    output logic [7:0]           ireq_tkeep_o,
    output logic [31:0]          ireq_tuser_o
`ifdef DB_STATS_EN
    ,
    output logic [31:0]          db_sent_cnt_o,
    output logic [15:0]          db_drop_cnt_o
`endif
);

    localparam int             PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W:0] NUM_CH_W = (PTR_W + 1)'(NUM_CH);
    localparam logic [3:0]     FTYPE_DB = 4'hA;
    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_SEND  = 1'b1;

    logic [0:0]        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [7:0]        tid;
    logic [NUM_CH-1:0] db_req_r;
    logic [NUM_CH-1:0] pending;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] drop_vec;
    logic [NUM_CH-1:0] pending_nxt;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    scan_idx;
    logic              grant_vld;
    logic              accept;
    logic              do_grant;
    logic [7:0]        tid_use;
    logic [15:0]       grant_info;

    // Search starts at the round-robin pointer and wraps, so the lowest index
    // at or after the pointer wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rise      = db_req_in & ~db_req_r;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (scan_idx >= NUM_CH_W) scan_idx = scan_idx - NUM_CH_W;
            if (!grant_vld && pending[scan_idx[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[PTR_W-1:0];
            end
        end
        accept   = ireq_tvalid_o & ireq_tready_in;
        do_grant = grant_vld & ((state == ST_IDLE) | accept);
        grant_oh = '0;
        if (do_grant) grant_oh[grant_idx] = 1'b1;
        // A rise on the channel being granted re-queues it instead of dropping.
        drop_vec    = rise & pending & ~grant_oh;
        pending_nxt = (pending & ~grant_oh) | rise;
        tid_use     = accept ? tid + 8'd1 : tid;
        grant_info  = db_info_in[{grant_idx, 4'b0000} +: 16];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge log_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            tid           <= TID_INIT;
            db_req_r      <= '0;
            pending       <= '0;
            db_drop_o     <= '0;
            ireq_tvalid_o <= 1'b0;
            ireq_tlast_o  <= 1'b0;
            ireq_tdata_o  <= '0;
            ireq_tkeep_o  <= '0;
            ireq_tuser_o  <= '0;
        end else begin
            db_req_r  <= db_req_in;
            pending   <= pending_nxt;
            db_drop_o <= drop_vec;
            if (accept) tid <= tid + 8'd1;
            if (do_grant) begin
                state         <= ST_SEND;
                rr_ptr        <= (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                ireq_tvalid_o <= 1'b1;
                ireq_tlast_o  <= 1'b1;
                ireq_tkeep_o  <= 8'hFF;
                ireq_tuser_o  <= {src_id, des_id};
                ireq_tdata_o  <= {tid_use, FTYPE_DB, 4'b0000, 1'b0, PRIO, 1'b0,
                                  12'h000, grant_info, 16'h0000};
            end else if (accept) begin
                state         <= ST_IDLE;
                ireq_tvalid_o <= 1'b0;
                ireq_tlast_o  <= 1'b0;
                ireq_tkeep_o  <= '0;
                ireq_tuser_o  <= '0;
                ireq_tdata_o  <= '0;
            end
        end
    end

    assign db_pending_o = pending;
    assign busy_o       = ireq_tvalid_o;

`ifdef DB_STATS_EN
    // Sent count wraps; drop count saturates.
    always_ff @(posedge log_clk or posedge rst) begin
        if (rst) begin
            db_sent_cnt_o <= '0;
            db_drop_cnt_o <= '0;
        end else begin
            if (accept) db_sent_cnt_o <= db_sent_cnt_o + 32'd1;
            if ((|db_drop_o) && (db_drop_cnt_o != 16'hFFFF)) db_drop_cnt_o <= db_drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_db_req_arb.sv
// Directed self-checking bench for db_req_arb (NUM_CH=4, PRIO=1, TID_INIT=0).
module tb_db_req_arb;

    logic        log_clk;
    logic        rst;
    logic [15:0] src_id;
    logic [15:0] des_id;
    logic [3:0]  db_req_in;
    logic [63:0] db_info_in;
    logic [3:0]  db_pending_o;
    logic [3:0]  db_drop_o;
    logic        busy_o;
    logic        ireq_tvalid_o;
    logic        ireq_tready_in;
    logic        ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;
`ifdef DB_STATS_EN
    logic [31:0] db_sent_cnt_o;
    logic [15:0] db_drop_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    db_req_arb #(.NUM_CH(4), .PRIO(2'h1), .TID_INIT(8'h00)) dut (
        .log_clk        (log_clk),
        .rst            (rst),
        .src_id         (src_id),
        .des_id         (des_id),
        .db_req_in      (db_req_in),
        .db_info_in     (db_info_in),
        .db_pending_o   (db_pending_o),
        .db_drop_o      (db_drop_o),
        .busy_o         (busy_o),
        .ireq_tvalid_o  (ireq_tvalid_o),
        .ireq_tready_in (ireq_tready_in),
        .ireq_tlast_o   (ireq_tlast_o),
        .ireq_tdata_o   (ireq_tdata_o),
        .ireq_tkeep_o   (ireq_tkeep_o),
        .ireq_tuser_o   (ireq_tuser_o)
`ifdef DB_STATS_EN
        ,
        .db_sent_cnt_o  (db_sent_cnt_o),
        .db_drop_cnt_o  (db_drop_cnt_o)
`endif
    );

    initial begin
        log_clk = 1'b0;
        forever #5 log_clk = ~log_clk;
    end

    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Doorbell header with PRIO=1: {tid, A, 0, 0010, 000, info, 0000}.
    function automatic logic [63:0] hdr(input logic [7:0] t, input logic [15:0] info);
        return {t, 4'hA, 4'h0, 4'h2, 12'h000, info, 16'h0000};
    endfunction

    initial begin
        rst            = 1'b1;
        src_id         = 16'h1234;
        des_id         = 16'h5678;
        db_req_in      = 4'b0000;
        db_info_in     = '0;
        ireq_tready_in = 1'b1;
        #3;
        chk("rst_tvalid", ireq_tvalid_o, 0);
        chk("rst_tdata", ireq_tdata_o, 0);
        chk("rst_pending", db_pending_o, 0);
        chk("rst_drop", db_drop_o, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request on ch2
        db_info_in[47:32] = 16'h0101;
        db_req_in = 4'b0100;
        tick();
        chk("single_pend", db_pending_o, 4'b0100);
        chk("single_lat", ireq_tvalid_o, 0);
        tick();
        chk("single_valid", ireq_tvalid_o, 1);
        chk("single_busy", busy_o, 1);
        chk("single_tdata", ireq_tdata_o, 64'h00A0_2000_0101_0000);
        chk("single_tuser", ireq_tuser_o, 32'h1234_5678);
        chk("single_tkeep", ireq_tkeep_o, 8'hFF);
        chk("single_tlast", ireq_tlast_o, 1);
        chk("single_pclr", db_pending_o, 0);
        tick();
        chk("single_end", ireq_tvalid_o, 0);
        chk("single_tdata0", ireq_tdata_o, 0);
        db_req_in = 4'b0000;

        // Fresh reset so the round-robin pointer and srcTID start at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Round-robin: all four channels rise together
        db_info_in = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        db_req_in = 4'b1111;
        tick();
        chk("rr_pend", db_pending_o, 4'b1111);
        db_req_in = 4'b0000;
        tick();
        chk("rr_b0", ireq_tdata_o, 64'h00A0_2000_C000_0000);
        tick();
        chk("rr_b1", ireq_tdata_o, hdr(8'h01, 16'hC001));
        tick();
        chk("rr_b2", ireq_tdata_o, hdr(8'h02, 16'hC002));
        tick();
        chk("rr_b3", ireq_tdata_o, 64'h03A0_2000_C003_0000);
        chk("rr_b3_valid", ireq_tvalid_o, 1);
        tick();
        chk("rr_end", ireq_tvalid_o, 0);

        // Backpressure: packet held while info/src_id change
        ireq_tready_in = 1'b0;
        db_req_in = 4'b0010;
        tick();
        db_req_in = 4'b0000;
        tick();
        chk("bp_first", ireq_tdata_o, hdr(8'h04, 16'hC001));
        db_info_in[31:16] = 16'hBEEF;
        src_id = 16'hAAAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_tdata_hold", ireq_tdata_o, 64'h04A0_2000_C001_0000);
            chk("bp_tuser_hold", ireq_tuser_o, 32'h1234_5678);
            chk("bp_valid_hold", ireq_tvalid_o, 1);
        end
        ireq_tready_in = 1'b1;
        tick();
        chk("bp_accept", ireq_tvalid_o, 0);

        // Drop: ch1 pulses twice while ch3's packet is stalled
        db_info_in = {16'h3333, 16'h2222, 16'h1111, 16'h0A0A};
        ireq_tready_in = 1'b0;
        db_req_in = 4'b1000;
        tick();
        db_req_in = 4'b0000;
        tick();
        chk("drop_ch3_pkt", ireq_tdata_o, hdr(8'h05, 16'h3333));
        db_req_in = 4'b0010;
        tick();
        chk("drop_first_ok", db_drop_o, 0);
        chk("drop_pend", db_pending_o, 4'b0010);
        db_req_in = 4'b0000;
        tick();
        db_req_in = 4'b0010;
        tick();
        chk("drop_pulse", db_drop_o, 4'b0010);
        chk("drop_pend_keep", db_pending_o, 4'b0010);
        db_req_in = 4'b0000;
        tick();
        chk("drop_pulse_end", db_drop_o, 0);
        ireq_tready_in = 1'b1;
        tick();
        chk("drop_b2b_valid", ireq_tvalid_o, 1);
        chk("drop_ch1_pkt", ireq_tdata_o, 64'h06A0_2000_1111_0000);
        chk("drop_tuser_new", ireq_tuser_o, 32'hAAAA_5678);
        tick();
        chk("drop_done", ireq_tvalid_o, 0);
        chk("drop_pend_clr", db_pending_o, 0);
`ifdef DB_STATS_EN
        chk("stats_drop", db_drop_cnt_o, 16'd1);
        chk("stats_sent", db_sent_cnt_o, 32'd7);
`endif

        // Grant+rise collision on ch0
        ireq_tready_in = 1'b0;
        db_req_in = 4'b0100;
        tick();
        db_req_in = 4'b0000;
        tick();
        chk("col_ch2_pkt", ireq_tdata_o, hdr(8'h07, 16'h2222));
        db_req_in = 4'b0001;
        tick();
        db_req_in = 4'b0000;
        tick();
        db_req_in = 4'b0001;
        ireq_tready_in = 1'b1;
        tick();
        chk("col_pkt1", ireq_tdata_o, hdr(8'h08, 16'h0A0A));
        chk("col_pend", db_pending_o, 4'b0001);
        chk("col_nodrop", db_drop_o, 0);
        tick();
        chk("col_pkt2", ireq_tdata_o, hdr(8'h09, 16'h0A0A));
        chk("col_valid2", ireq_tvalid_o, 1);
        chk("col_pend_clr", db_pending_o, 0);
        tick();
        chk("col_end", ireq_tvalid_o, 0);
        db_req_in = 4'b0000;
`ifdef DB_STATS_EN
        chk("stats_drop2", db_drop_cnt_o, 16'd1);
`endif

        // Reset mid-packet
        ireq_tready_in = 1'b0;
        db_req_in = 4'b1000;
        tick();
        db_req_in = 4'b0010;
        tick();
        chk("mrst_valid_pre", ireq_tvalid_o, 1);
        chk("mrst_pend_pre", db_pending_o, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", ireq_tvalid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_tdata", ireq_tdata_o, 0);
        chk("mrst_pend", db_pending_o, 0);
        tick();
        rst = 1'b0;
        db_req_in = 4'b0000;
        ireq_tready_in = 1'b1;
        tick();
        tick();
        chk("mrst_lost", ireq_tvalid_o, 0);

        // srcTID wrap over 257 packets on ch0
        for (int n = 0; n < 257; n++) begin
            db_req_in = 4'b0001;
            tick();
            db_req_in = 4'b0000;
            tick();
            if (n == 0)   chk("wrap_tid0", ireq_tdata_o[63:56], 8'h00);
            if (n == 255) chk("wrap_tid255", ireq_tdata_o[63:56], 8'hFF);
            if (n == 256) begin
                chk("wrap_valid", ireq_tvalid_o, 1);
                chk("wrap_tid256", ireq_tdata_o[63:56], 8'h00);
            end
        end
        tick();
        chk("wrap_end", ireq_tvalid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
